// File: rtl/ntt_pe_sched.sv
// Stage/butterfly scheduler for one radix-2 DIT NTT processing element.
// It walks the N_LOG stages in order. Each stage issues N reads, two per
// butterfly with the odd element first, then waits PE_LAT cycles so the
// pipeline drains before the next stage reads. Write-back is the read stream
// delayed by PE_LAT cycles, so every result goes back to the address it came
// from (in-place).
module ntt_pe_sched #(
  parameter int N_LOG  = 6,
  parameter int PE_LAT = 14,
  localparam int SW    = (N_LOG > 1) ? $clog2(N_LOG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pe_start,
  output logic             sel_a,
  output logic             sel_b,
  output logic             rd_en,
  output logic [N_LOG-1:0] rd_addr,
  output logic [N_LOG-2:0] tw_addr,
  output logic             wr_en,
  output logic [N_LOG-1:0] wr_addr,
  output logic [SW-1:0]    stage
);

  localparam int KW = N_LOG - 1;
  localparam int DW = $clog2(PE_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [N_LOG-1:0]  cnt_q, cnt_d;   // issue cycle: {k, phase}
  logic [DW-1:0]     drn_q, drn_d;   // drain cycle counter

  // Delay line carrying {rd_en, rd_addr, sel_a} to the write port
  logic [PE_LAT-1:0] dl_en_q, dl_en_d;
  logic [PE_LAT-1:0] dl_sel_q, dl_sel_d;
  logic [N_LOG-1:0]  dl_addr_q [PE_LAT];
  logic [N_LOG-1:0]  dl_addr_d [PE_LAT];

  // Butterfly address arithmetic
  logic [KW-1:0]     k_v;
  logic [KW-1:0]     hs_v;
  logic [KW-1:0]     j_v;
  logic [N_LOG-1:0]  k_ext;
  logic [N_LOG-1:0]  half_v;
  logic [N_LOG-1:0]  even_v;
  logic [N_LOG-1:0]  odd_v;
  logic [KW-1:0]     tw_v;
  logic              issue;

  // State register for the FSM and its counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  // Next-state logic plus the state-decoded status outputs
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    busy     = 1'b0;
    done     = 1'b0;
    pe_start = 1'b0;
    issue    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        busy     = 1'b1;
        pe_start = 1'b1;
        issue    = 1'b1;
        cnt_d    = cnt_q + N_LOG'(1);
        if (cnt_q == {N_LOG{1'b1}}) begin
          state_d = S_DRAIN;
          drn_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        busy     = 1'b1;
        pe_start = 1'b1;
        drn_d    = drn_q + DW'(1);
        if (drn_q == DW'(PE_LAT - 1)) begin
          drn_d = '0;
          cnt_d = '0;
          if (stage_q == SW'(N_LOG - 1)) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + SW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
        stage_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read/twiddle address generation for butterfly k of the current stage
  always_comb begin
    k_v    = cnt_q[N_LOG-1:1];
    k_ext  = {1'b0, k_v};
    // In the last stage hs_v wraps to 0, so the mask becomes all ones and j = k
    hs_v   = KW'(1) << stage_q;
    j_v    = k_v & (hs_v - KW'(1));
    half_v = N_LOG'(1) << stage_q;
    even_v = (((k_ext >> stage_q) << 1) << stage_q) + {1'b0, j_v};
    odd_v  = even_v + half_v;
    tw_v   = j_v << (SW'(N_LOG - 1) - stage_q);

    rd_en   = issue;
    sel_a   = issue & ~cnt_q[0];
    rd_addr = '0;
    tw_addr = '0;
    if (issue) begin
      rd_addr = cnt_q[0] ? even_v : odd_v;
      tw_addr = tw_v;
    end
    stage = stage_q;
  end

  // Shift the read stream one slot down the write-back delay line
  always_comb begin
    dl_en_d      = {dl_en_q[PE_LAT-2:0], rd_en};
    dl_sel_d     = {dl_sel_q[PE_LAT-2:0], sel_a};
    dl_addr_d[0] = rd_addr;
    for (int i = 1; i < PE_LAT; i++) begin
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  // Delay-line control bits; cleared on reset so no stale write escapes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_en_q  <= '0;
      dl_sel_q <= '0;
    end else begin
      dl_en_q  <= dl_en_d;
      dl_sel_q <= dl_sel_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PE_LAT; gi++) begin : g_dl_addr
      // One address slot of the write-back delay line
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dl_addr_q[gi] <= '0;
        end else begin
          dl_addr_q[gi] <= dl_addr_d[gi];
        end
      end
    end
  endgenerate

  assign wr_en   = dl_en_q[PE_LAT-1];
  assign sel_b   = dl_sel_q[PE_LAT-1];
  assign wr_addr = dl_addr_q[PE_LAT-1];

endmodule
